xm_mw_bypass: RTL

XM_MW_BYPASS -- requirements
Module: xm_mw_bypass

---
 rtl/xm_mw_bypass_pkg.sv | 26 ++
 rtl/xm_mw_bypass_bypass_match.sv | 30 +++
 rtl/xm_mw_bypass.sv | 125 ++++++++++++
 3 files changed

// File: rtl/xm_mw_bypass_pkg.sv
// Shared widths, select-bit positions and latch payload for the X/M and M/W bypass block.
package xm_mw_bypass_pkg;

    localparam int unsigned DataW    = 32;
    localparam int unsigned RegW     = 5;
    localparam int unsigned SelW     = 2;
    localparam int unsigned SelXm    = 0;
    localparam int unsigned SelMw    = 1;
    localparam int unsigned NumLanes = 2;

    localparam logic [RegW-1:0] RegZero = RegW'(0);

    typedef struct packed {
        logic            valid;
        logic            wen;
        logic            isLoad;
        logic [RegW-1:0] rd;
        logic [DataW-1:0] data;
    } latchEntry_t;

    // A latched entry that will really write src (never register 0).
    function automatic logic destHit(input latchEntry_t e, input logic [RegW-1:0] src);
        return e.valid && e.wen && (e.rd != RegZero) && (e.rd == src);
    endfunction

endpackage

// File: rtl/xm_mw_bypass_bypass_match.sv
// Compares one D/X source register against the four latched destinations (own and other lane, X/M and M/W).
module bypass_match
    import xm_mw_bypass_pkg::*;
(
    input  logic [RegW-1:0] src,
    input  latchEntry_t     ownXm,
    input  latchEntry_t     ownMw,
    input  latchEntry_t     crossXm,
    input  latchEntry_t     crossMw,
    output logic [SelW-1:0] ownSel_c,
    output logic [SelW-1:0] crossSel_c,
    output logic            loadUse_c
);

    // A load still in X/M has no data yet: it stalls instead of forwarding.
    always_comb begin
        ownSel_c   = '0;
        crossSel_c = '0;
        loadUse_c  = 1'b0;

        ownSel_c[SelXm]   = destHit(ownXm, src) && !ownXm.isLoad;
        ownSel_c[SelMw]   = destHit(ownMw, src);
        crossSel_c[SelXm] = destHit(crossXm, src) && !crossXm.isLoad;
        crossSel_c[SelMw] = destHit(crossMw, src);

        loadUse_c = (destHit(ownXm, src) && ownXm.isLoad) ||
                    (destHit(crossXm, src) && crossXm.isLoad);
    end

endmodule

// File: rtl/xm_mw_bypass.sv
// Dual-lane X/M and M/W pipeline latches with bypass selects, load-use stall and register-file write port.
module xm_mw_bypass
    import xm_mw_bypass_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             ex_valid_top,
    input  logic             ex_valid_bot,
    input  logic [DataW-1:0] ex_result_top,
    input  logic [DataW-1:0] ex_result_bot,
    input  logic [RegW-1:0]  ex_rd_top,
    input  logic [RegW-1:0]  ex_rd_bot,
    input  logic             ex_wen_top,
    input  logic             ex_wen_bot,
    input  logic             ex_isLoad_top,
    input  logic             ex_isLoad_bot,
    input  logic [DataW-1:0] mem_rdata_top,
    input  logic [DataW-1:0] mem_rdata_bot,
    input  logic [RegW-1:0]  dx_rs_top,
    input  logic [RegW-1:0]  dx_rs_bot,
    input  logic [RegW-1:0]  dx_rt_top,
    input  logic [RegW-1:0]  dx_rt_bot,
    input  logic             hold,
    input  logic             flush,
    output logic [DataW-1:0] xmOVR_top,
    output logic [DataW-1:0] xmOVR_bot,
    output logic [DataW-1:0] mwOVR_top,
    output logic [DataW-1:0] mwOVR_bot,
    output logic [SelW-1:0]  overWriteRS_top,
    output logic [SelW-1:0]  overWriteRS_bot,
    output logic [SelW-1:0]  overWriteRT_top,
    output logic [SelW-1:0]  overWriteRT_bot,
    output logic [SelW-1:0]  cross_overWriteRS_top,
    output logic [SelW-1:0]  cross_overWriteRS_bot,
    output logic [SelW-1:0]  cross_overWriteRT_top,
    output logic [SelW-1:0]  cross_overWriteRT_bot,
    output logic [DataW-1:0] wb_data_top,
    output logic [DataW-1:0] wb_data_bot,
    output logic [RegW-1:0]  wb_rd_top,
    output logic [RegW-1:0]  wb_rd_bot,
    output logic             wb_wen_top,
    output logic             wb_wen_bot,
    output logic             loadUseStall
);

    latchEntry_t exTop, exBot;
    latchEntry_t xmTop, xmBot;
    latchEntry_t mwTop, mwBot;
    logic [2*NumLanes-1:0] loadUseVec;
    logic wbWenTopRaw, wbWenBotRaw;

    function automatic latchEntry_t toMw(input latchEntry_t xm, input logic [DataW-1:0] rdata);
        latchEntry_t e;
        e = xm;
        if (xm.isLoad) begin
            e.data = rdata;
        end
        return e;
    endfunction

    always_comb begin
        exTop = '{valid: ex_valid_top, wen: ex_wen_top, isLoad: ex_isLoad_top,
                  rd: ex_rd_top, data: ex_result_top};
        exBot = '{valid: ex_valid_bot, wen: ex_wen_bot, isLoad: ex_isLoad_bot,
                  rd: ex_rd_bot, data: ex_result_bot};
        if (flush) begin
            exTop.valid = 1'b0;
            exBot.valid = 1'b0;
        end
    end

    // Hold freezes both stages and overrides flush; flush only kills what enters X/M.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            xmTop <= '0;
            xmBot <= '0;
            mwTop <= '0;
            mwBot <= '0;
        end else if (!hold) begin
            xmTop <= exTop;
            xmBot <= exBot;
            mwTop <= toMw(xmTop, mem_rdata_top);
            mwBot <= toMw(xmBot, mem_rdata_bot);
        end
    end

    bypass_match u_rsTop (
        .src(dx_rs_top), .ownXm(xmTop), .ownMw(mwTop), .crossXm(xmBot), .crossMw(mwBot),
        .ownSel_c(overWriteRS_top), .crossSel_c(cross_overWriteRS_top), .loadUse_c(loadUseVec[0])
    );

    bypass_match u_rtTop (
        .src(dx_rt_top), .ownXm(xmTop), .ownMw(mwTop), .crossXm(xmBot), .crossMw(mwBot),
        .ownSel_c(overWriteRT_top), .crossSel_c(cross_overWriteRT_top), .loadUse_c(loadUseVec[1])
    );

    bypass_match u_rsBot (
        .src(dx_rs_bot), .ownXm(xmBot), .ownMw(mwBot), .crossXm(xmTop), .crossMw(mwTop),
        .ownSel_c(overWriteRS_bot), .crossSel_c(cross_overWriteRS_bot), .loadUse_c(loadUseVec[2])
    );

    bypass_match u_rtBot (
        .src(dx_rt_bot), .ownXm(xmBot), .ownMw(mwBot), .crossXm(xmTop), .crossMw(mwTop),
        .ownSel_c(overWriteRT_bot), .crossSel_c(cross_overWriteRT_bot), .loadUse_c(loadUseVec[3])
    );

    assign loadUseStall = |loadUseVec;

    assign xmOVR_top = xmTop.data;
    assign xmOVR_bot = xmBot.data;
    assign mwOVR_top = mwTop.data;
    assign mwOVR_bot = mwBot.data;

    assign wb_data_top = mwTop.data;
    assign wb_data_bot = mwBot.data;
    assign wb_rd_top   = mwTop.rd;
    assign wb_rd_bot   = mwBot.rd;

    // Same-register double write: the younger bot lane wins.
    assign wbWenTopRaw = mwTop.valid && mwTop.wen && (mwTop.rd != RegZero);
    assign wbWenBotRaw = mwBot.valid && mwBot.wen && (mwBot.rd != RegZero);
    assign wb_wen_bot  = wbWenBotRaw;
    assign wb_wen_top  = wbWenTopRaw && !(wbWenBotRaw && (mwBot.rd == mwTop.rd));

endmodule
